// File: rtl/bnn_stream_core_if.sv
// rtl/bnn_stream_core_if.sv - input, load and result streams of the binary neural network core
//
// Signals:
//   in_valid/in_data/in_ready     input vector stream (master drives vector, core drives ready)
//   ld_start                      begins or restarts a model load sequence
//   ld_valid/ld_data/ld_ready     model load beat stream
//   ld_done                       one-cycle pulse when a new model is committed
//   out_valid/out_data/out_class  inference results (no backpressure)
// Modports: master = stimulus side, slave = core side.
interface bnn_stream_core_if #(
    parameter int N_IN  = 8,
    parameter int N_HID = 8,
    parameter int N_OUT = 4,
    parameter int LD_W  = 4
);
    localparam int CLS_W = $clog2(N_OUT);

    logic              in_valid;
    logic [N_IN-1:0]   in_data;
    logic              in_ready;
    logic              ld_start;
    logic              ld_valid;
    logic [LD_W-1:0]   ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              out_valid;
    logic [N_OUT-1:0]  out_data;
    logic [CLS_W-1:0]  out_class;

    modport master (
        output in_valid, in_data, ld_start, ld_valid, ld_data,
        input  in_ready, ld_ready, ld_done, out_valid, out_data, out_class
    );

    modport slave (
        input  in_valid, in_data, ld_start, ld_valid, ld_data,
        output in_ready, ld_ready, ld_done, out_valid, out_data, out_class
    );
endinterface

// File: rtl/bnn_stream_core.sv
// rtl/bnn_stream_core.sv - two-layer XNOR-popcount binary neural network with atomic model reload
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    bnn_stream_core_if.slave: input vector stream, model load stream, result stream
//
// The model lives in one flat image: per hidden neuron {threshold, weights}, then per output
// neuron {threshold, weights}, each threshold padded to a whole number of load beats. Because
// beats arrive in exactly that order, the shadow copy is a shift register that takes each beat
// at the top; after the final beat the first beat sits at bit 0.
module bnn_stream_core #(
    parameter int N_IN  = 8,
    parameter int N_HID = 8,
    parameter int N_OUT = 4,
    parameter int LD_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    bnn_stream_core_if.slave bus
);
    localparam int MAX_FAN  = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int CNT_W    = $clog2(MAX_FAN + 1);
    localparam int TH_BEATS = (CNT_W + LD_W - 1) / LD_W;
    localparam int CLS_W    = $clog2(N_OUT);
    localparam int TH_PAD   = TH_BEATS * LD_W;
    localparam int HREC     = N_IN + TH_PAD;
    localparam int OREC     = N_HID + TH_PAD;
    localparam int HBITS    = N_HID * HREC;
    localparam int IMG_W    = HBITS + N_OUT * OREC;
    localparam int N_BEATS  = IMG_W / LD_W;
    localparam int PTR_W    = $clog2(N_BEATS);

    function automatic logic [IMG_W-1:0] default_image();
        logic [IMG_W-1:0] img;
        img = '0;
        for (int h = 0; h < N_HID; h++) begin
            img[h*HREC +: N_IN]          = '1;
            img[h*HREC + N_IN +: TH_PAD] = TH_PAD'(N_IN);
        end
        for (int o = 0; o < N_OUT; o++) begin
            img[HBITS + o*OREC +: N_HID]          = '1;
            img[HBITS + o*OREC + N_HID +: TH_PAD] = TH_PAD'(N_HID);
        end
        return img;
    endfunction

    localparam logic [IMG_W-1:0] RESET_IMG = default_image();

    // Narrower vectors are zero-extended by the caller, so padding bits never count.
    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_FAN-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_FAN; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_DRAIN, S_COMMIT} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [IMG_W-1:0]   shadow;
    logic [IMG_W-1:0]   active;
    logic               in_ready_q;
    logic               ld_ready_q;
    logic               ld_done_q;
    logic               s1_valid;
    logic [N_HID-1:0]   hid_q;
    logic               out_valid_q;
    logic [N_OUT-1:0]   out_data_q;
    logic [CLS_W-1:0]   out_class_q;

    logic [N_HID-1:0]   hid_act;
    logic [N_OUT-1:0]   out_act;
    logic [CLS_W-1:0]   best_idx;

    assign bus.in_ready  = in_ready_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.ld_done   = ld_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_class = out_class_q;

    // Layer 1: thresholds are the low CNT_W bits of their padded field.
    always_comb begin
        logic [N_IN-1:0]  xh;
        logic [CNT_W-1:0] pc;
        hid_act = '0;
        xh      = '0;
        pc      = '0;
        for (int h = 0; h < N_HID; h++) begin
            xh         = ~(bus.in_data ^ active[h*HREC +: N_IN]);
            pc         = popcount(MAX_FAN'(xh));
            hid_act[h] = (pc >= active[h*HREC + N_IN +: CNT_W]);
        end
    end

    // Layer 2 plus argmax: strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        logic [N_HID-1:0] xo;
        logic [CNT_W-1:0] pc;
        logic [CNT_W-1:0] best_pc;
        out_act  = '0;
        best_idx = '0;
        best_pc  = '0;
        xo       = '0;
        pc       = '0;
        for (int o = 0; o < N_OUT; o++) begin
            xo         = ~(hid_q ^ active[HBITS + o*OREC +: N_HID]);
            pc         = popcount(MAX_FAN'(xo));
            out_act[o] = (pc >= active[HBITS + o*OREC + N_HID +: CNT_W]);
            if (o == 0 || pc > best_pc) begin
                best_pc  = pc;
                best_idx = CLS_W'(o);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            ptr         <= '0;
            shadow      <= RESET_IMG;
            active      <= RESET_IMG;
            in_ready_q  <= 1'b1;
            ld_ready_q  <= 1'b0;
            ld_done_q   <= 1'b0;
            s1_valid    <= 1'b0;
            hid_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_class_q <= '0;
        end else begin
            ld_done_q <= 1'b0;

            // Inference pipeline; inputs are only accepted in RUN, so it drains during a load.
            s1_valid <= bus.in_valid && in_ready_q;
            if (bus.in_valid && in_ready_q) hid_q <= hid_act;
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_data_q  <= out_act;
                out_class_q <= best_idx;
            end

            case (state)
                S_RUN: begin
                    if (bus.ld_start) begin
                        state      <= S_LOAD;
                        ptr        <= '0;
                        in_ready_q <= 1'b0;
                        ld_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_start) begin
                        ptr <= '0;
                    end else if (bus.ld_valid && ld_ready_q) begin
                        shadow <= {bus.ld_data, shadow[IMG_W-1:LD_W]};
                        if (ptr == PTR_W'(N_BEATS - 1)) begin
                            state      <= S_DRAIN;
                            ld_ready_q <= 1'b0;
                        end else begin
                            ptr <= ptr + PTR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Results already in flight finish with the old model before the swap.
                    if (!s1_valid && !out_valid_q) begin
                        state     <= S_COMMIT;
                        ld_done_q <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    active     <= shadow;
                    state      <= S_RUN;
                    in_ready_q <= 1'b1;
                end
                default: state <= S_RUN;
            endcase
        end
    end
endmodule

// File: doc/bnn_stream_core.md
Name: bnn_stream_core

Overview:
Parametrised two-layer binary neural network (N_IN inputs, N_HID hidden neurons, N_OUT output neurons) with XNOR-popcount neurons and a programmable threshold per neuron. Weights and thresholds load through a ready/valid beat stream into shadow registers. The shadow set commits atomically, so inference never sees a half-loaded model. Inference runs as a valid-tagged 2-stage pipeline that also reports the argmax class. This block replaces the fixed 8-8-4 core behind the top-level pin wrapper.

Parameters:
N_IN, 8, input vector width; must be a multiple of LD_W
N_HID, 8, hidden neurons; must be a multiple of LD_W
N_OUT, 4, output neurons, >=2
LD_W, 4, load beat width
(derived, not overridable) CNT_W = $clog2(max(N_IN,N_HID)+1); TH_BEATS = ceil(CNT_W/LD_W); CLS_W = $clog2(N_OUT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input vector valid
in_data  in  N_IN  input vector
in_ready  out  1  high only in state RUN
ld_start  in  1  begins or restarts a load sequence
ld_valid  in  1  load beat valid
ld_data  in  LD_W  load beat
ld_ready  out  1  high only in state LOAD
ld_done  out  1  one-cycle pulse when new model committed
out_valid  out  1  result valid (pulse, no backpressure)
out_data  out  N_OUT  output neuron activations
out_class  out  CLS_W  index of max layer-2 popcount

Behaviour:
- Reset values. All outputs 0 except in_ready=1. State RUN. Pipeline valids 0.
- Reset model (active and shadow): all weights 1. Hidden thresholds = N_IN. Output thresholds = N_HID.
- Neuron function: popcount over bits of (x XNOR w), CNT_W bits wide; fires iff popcount >= threshold (unsigned). Threshold 0 means always fire; threshold > fan-in means never fire.
- Pipeline:
  - Stage 1 registers hidden activations when in_valid && in_ready.
  - Stage 2 registers out_data, out_class and out_valid.
  - Latency is exactly 2 cycles. One result per cycle when streaming.
- out_class: highest layer-2 popcount; lowest index wins ties. Computed from the popcounts, not the thresholds.
- Load beat order:
  - For each hidden neuron 0..N_HID-1: N_IN/LD_W weight beats (weight bits [LD_W-1:0] first), then TH_BEATS threshold beats (LSB first, excess bits dropped).
  - Then for each output neuron 0..N_OUT-1: N_HID/LD_W weight beats, then TH_BEATS threshold beats.
  - Defaults give 36 beats total.
- A beat is accepted when ld_valid && ld_ready. The beat pointer advances by 1 per accepted beat.
- FSM:
  - RUN: ld_start -> LOAD with pointer cleared. An input accepted in the same cycle still completes with the old model.
  - LOAD: accepts beats into shadow. ld_start -> pointer cleared, a coincident beat is dropped, shadow contents partially stale but fully overwritten before commit. Last beat accepted -> DRAIN.
  - DRAIN: wait until both pipeline valids are 0 -> COMMIT.
  - COMMIT (1 cycle): shadow copied to active, ld_done=1 -> RUN.
- ld_start outside RUN/LOAD is ignored. ld_valid outside LOAD is ignored.
- in_ready is 0 in LOAD/DRAIN/COMMIT. The active model never changes except in COMMIT.
- Abort: a load is abandoned only by restart (ld_start) or reset. An abandoned load leaves the active model untouched.
- Reset mid-load restores the reset model and state RUN immediately.

Test Plan:
1. After reset, in_data all ones -> 2 cycles later out_valid=1, out_data=4'hF, out_class=0. in_data=8'hFE -> out_data=0, out_class=0 (all popcounts equal).
2. Load hidden weights 8'h0F, threshold 4; output weights 8'hFF, threshold 8 (36 beats) -> ld_done pulses once, in_ready returns high next cycle. in 8'h0F -> out_data=4'hF. in 8'hF0 -> out_data=4'h0.
3. Stream in_valid for 3 consecutive cycles (8'hFF, 8'hFE, 8'hFF) -> out_valid high for 3 consecutive cycles starting 2 cycles after the first, data F,0,F.
4. ld_start in the same cycle as an accepted input -> that result uses the old model. DRAIN holds until out_valid has fired, then COMMIT.
5. ld_start again after 10 beats, then full 36 beats of test-2 model -> a single ld_done. Test-2 results match; the first partial load has no effect.
6. Assert reset after 20 beats -> in_ready=1, ld_ready=0, model back to reset defaults (repeat test 1 and get the same results).
